// File: rtl/mem_port_arb.sv
// Shares one single-port SRAM between instruction fetch and load/store; LS wins unless fetch has starved.
// Latency: combinational grant, read response one cycle after grant.
// Backpressure: the losing requester sees ready=0 and must hold its request; flush blocks fetch grants.
module mem_port_arb #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_valid,
    input  logic [AW-1:0]   if_req_addr,
    output logic            if_req_ready,
    input  logic            if_flush,
    output logic            if_rsp_valid,
    output logic [DW-1:0]   if_rsp_data,
    input  logic            ls_req_valid,
    input  logic            ls_req_we,
    input  logic [DW/8-1:0] ls_req_be,
    input  logic [AW-1:0]   ls_req_addr,
    input  logic [DW-1:0]   ls_req_wdata,
    output logic            ls_req_ready,
    output logic            ls_rsp_valid,
    output logic [DW-1:0]   ls_rsp_data,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int BW = DW / 8;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } owner_t;

    owner_t          owner_q, owner_d;
    logic            store_q, store_d;
    logic [CW-1:0]   starve_cnt, starve_d;
    logic            if_elig, ls_elig, grant_if, grant_ls;

    // Grants are held off while reset is asserted so the SRAM stays idle.
    always_comb begin
        if_elig   = !rst && if_req_valid && !if_flush;
        ls_elig   = !rst && ls_req_valid;
        grant_if  = if_elig && (!ls_elig || (starve_cnt == LIMIT));
        grant_ls  = ls_elig && !grant_if;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_if) begin
            mem_en   = 1'b1;
            mem_be   = {BW{1'b1}};
            mem_addr = if_req_addr;
        end else if (grant_ls) begin
            mem_en    = 1'b1;
            mem_we    = ls_req_we;
            mem_be    = ls_req_be;
            mem_addr  = ls_req_addr;
            mem_wdata = ls_req_wdata;
        end

        if (!if_elig || grant_if) begin
            starve_d = '0;
        end else if (starve_cnt != LIMIT) begin
            starve_d = starve_cnt + CW'(1);
        end else begin
            starve_d = starve_cnt;
        end

        owner_d = OWN_NONE;
        store_d = 1'b0;
        if (grant_if) begin
            owner_d = OWN_IF;
        end else if (grant_ls) begin
            owner_d = OWN_LS;
            store_d = ls_req_we;
        end
    end

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            store_q    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            owner_q    <= owner_d;
            store_q    <= store_d;
            starve_cnt <= starve_d;
        end
    end

    // A flush in the response cycle kills a fetch response; LS responses always land.
    always_comb begin
        if_rsp_valid = (owner_q == OWN_IF) && !if_flush;
        if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
        ls_rsp_valid = (owner_q == OWN_LS);
        ls_rsp_data  = (ls_rsp_valid && !store_q) ? mem_rdata : '0;
    end

endmodule
